// File: rtl/vec_csr_pkg.sv
// Shared types, encodings and CSR addresses for the vector configuration/CSR unit.
// Imported by vec_vlmax_calc, vec_csr_unit and the bench.
package vec_csr_pkg;

  typedef enum logic [2:0] {
    VSETVLI  = 3'd0,
    VSETIVLI = 3'd1,
    VSETVL   = 3'd2,
    CSRRW    = 3'd3,
    CSRRS    = 3'd4,
    CSRRC    = 3'd5
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam logic [11:0] CSR_VSTART = 12'h008;
  localparam logic [11:0] CSR_VXSAT  = 12'h009;
  localparam logic [11:0] CSR_VXRM   = 12'h00A;
  localparam logic [11:0] CSR_VCSR   = 12'h00F;
  localparam logic [11:0] CSR_VL     = 12'hC20;
  localparam logic [11:0] CSR_VTYPE  = 12'hC21;
  localparam logic [11:0] CSR_VLENB  = 12'hC22;

  localparam logic [2:0] SEW_8  = 3'd0;
  localparam logic [2:0] SEW_16 = 3'd1;
  localparam logic [2:0] SEW_32 = 3'd2;
  localparam logic [2:0] SEW_64 = 3'd3;

  localparam logic [2:0] LMUL_1    = 3'd0;
  localparam logic [2:0] LMUL_2    = 3'd1;
  localparam logic [2:0] LMUL_4    = 3'd2;
  localparam logic [2:0] LMUL_8    = 3'd3;
  localparam logic [2:0] LMUL_RSVD = 3'd4;
  localparam logic [2:0] LMUL_F8   = 3'd5;
  localparam logic [2:0] LMUL_F4   = 3'd6;
  localparam logic [2:0] LMUL_F2   = 3'd7;

  // reserved is a single flag: set when any reserved vtype bit was nonzero.
  typedef struct packed {
    logic       vill;
    logic       reserved;
    logic       vma;
    logic       vta;
    logic [2:0] vsew;
    logic [2:0] vlmul;
  } vtype_t;

  localparam vtype_t VTYPE_ILL = '{vill: 1'b1, default: '0};

endpackage

// File: rtl/vec_vlmax_calc.sv
// Combinational map from (vsew, vlmul, reserved-bit flag) to VLMAX and vill.
// vlmax is forced to zero whenever the vtype is illegal.
module vec_vlmax_calc
  import vec_csr_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int VLEN = 128,
  parameter int ELEN = 32
) (
  input  logic [2:0]      vsew_i,
  input  logic [2:0]      vlmul_i,
  input  logic            rsvd_i,
  output logic [XLEN-1:0] vlmax_o,
  output logic            vill_o
);

  logic [31:0]     sew_bits;
  logic [31:0]     elen_frac;
  logic [2:0]      frac_sh;
  logic [XLEN-1:0] base;

  always_comb begin
    sew_bits  = 32'd8 << vsew_i;
    // Fractional LMUL 1/2^k is encoded as 8-k; 3-bit wraparound yields k.
    frac_sh   = 3'd0 - vlmul_i;
    elen_frac = 32'(ELEN) >> frac_sh;

    vill_o = rsvd_i
          || vsew_i[2]
          || (sew_bits > 32'(ELEN))
          || (vlmul_i == LMUL_RSVD)
          || (vlmul_i[2] && (sew_bits > elen_frac));

    base = XLEN'(VLEN) >> ({1'b0, vsew_i} + 4'd3);
    if (vlmul_i[2]) vlmax_o = base >> frac_sh;
    else            vlmax_o = base << vlmul_i[1:0];
    if (vill_o) vlmax_o = '0;
  end

endmodule

// File: rtl/vec_csr_unit.sv
// Vector configuration/CSR unit: vset{i}vl{i} and Zicsr access to the vector CSRs.
// Request accepted in IDLE, state commits leaving EXEC, response pulse follows RESP.
module vec_csr_unit
  import vec_csr_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int VLEN = 128,
  parameter int ELEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_op,
  input  logic [4:0]      req_rd_addr,
  input  logic [4:0]      req_rs1_addr,
  input  logic [XLEN-1:0] req_rs1_data,
  input  logic [XLEN-1:0] req_rs2_data,
  input  logic [10:0]     req_zimm,
  input  logic [11:0]     req_csr_addr,
  output logic            resp_valid,
  output logic [XLEN-1:0] resp_data,
  output logic            resp_illegal,
  input  logic            vstart_set,
  input  logic [XLEN-1:0] vstart_wdata,
  input  logic            vstart_clr,
  input  logic            vxsat_set,
  output logic [XLEN-1:0] vl,
  output logic [XLEN-1:0] vlmax,
  output logic [2:0]      vsew,
  output logic [2:0]      vlmul,
  output logic            vta,
  output logic            vma,
  output logic            vill,
  output logic [XLEN-1:0] vstart,
  output logic [1:0]      vxrm,
  output logic            vxsat
);

  localparam int VSTART_W = $clog2(VLEN);

  state_e                state_q;
  op_e                   op_q;
  logic                  rd_nz_q;
  logic [4:0]            rs1_addr_q;
  logic [XLEN-1:0]       rs1_data_q, rs2_data_q;
  logic [10:0]           zimm_q;
  logic [11:0]           csr_addr_q;

  logic [XLEN-1:0]       vl_q, vlmax_q;
  vtype_t                vtype_q;
  logic [VSTART_W-1:0]   vstart_q;
  logic [1:0]            vxrm_q;
  logic                  vxsat_q;
  logic                  resp_valid_q, resp_illegal_q;
  logic [XLEN-1:0]       resp_data_q;

  vtype_t                cand;
  logic [XLEN-1:0]       cand_vlmax, avl, vl_d;
  logic                  cand_vill;
  logic                  is_vset, is_csr;
  logic [XLEN-1:0]       csr_old, csr_wdata;
  logic                  csr_known, csr_ro, csr_we, csr_illegal;

  // NOTE: payload registers are only read while state_q qualifies them, so they carry no reset.
  always_ff @(posedge clk) begin
    if (req_valid && req_ready) begin
      op_q       <= op_e'(req_op);
      rd_nz_q    <= (req_rd_addr != 5'd0);
      rs1_addr_q <= req_rs1_addr;
      rs1_data_q <= req_rs1_data;
      rs2_data_q <= req_rs2_data;
      zimm_q     <= req_zimm;
      csr_addr_q <= req_csr_addr;
    end
  end

  // NOTE: every variable written here gets a default first so no latch is inferred.
  always_comb begin
    cand = '0;
    if (op_q == VSETVL) begin
      {cand.vma, cand.vta, cand.vsew, cand.vlmul} = rs2_data_q[7:0];
      cand.reserved = |rs2_data_q[XLEN-1:8];
    end else begin
      {cand.vma, cand.vta, cand.vsew, cand.vlmul} = zimm_q[7:0];
      cand.reserved = |zimm_q[10:8];
    end
  end

  vec_vlmax_calc #(.XLEN(XLEN), .VLEN(VLEN), .ELEN(ELEN)) u_vlmax_calc (
    .vsew_i  (cand.vsew),
    .vlmul_i (cand.vlmul),
    .rsvd_i  (cand.reserved),
    .vlmax_o (cand_vlmax),
    .vill_o  (cand_vill)
  );

  always_comb begin
    is_vset = (op_q == VSETVLI) || (op_q == VSETIVLI) || (op_q == VSETVL);
    is_csr  = (op_q == CSRRW) || (op_q == CSRRS) || (op_q == CSRRC);

    // rs1=x0 with rd=x0 keeps the old vl, clipped to the new VLMAX.
    if (op_q == VSETIVLI)        avl = XLEN'(rs1_addr_q);
    else if (rs1_addr_q != 5'd0) avl = rs1_data_q;
    else if (rd_nz_q)            avl = '1;
    else                         avl = vl_q;

    if (cand_vill)               vl_d = '0;
    else if (avl < cand_vlmax)   vl_d = avl;
    else                         vl_d = cand_vlmax;

    csr_known = 1'b1;
    csr_ro    = 1'b0;
    csr_old   = '0;
    case (csr_addr_q)
      CSR_VSTART: csr_old = XLEN'(vstart_q);
      CSR_VXSAT:  csr_old = XLEN'(vxsat_q);
      CSR_VXRM:   csr_old = XLEN'(vxrm_q);
      CSR_VCSR:   csr_old = XLEN'({vxrm_q, vxsat_q});
      CSR_VL:     begin csr_old = vl_q; csr_ro = 1'b1; end
      CSR_VTYPE:  begin csr_old = {vtype_q.vill, {(XLEN-10){1'b0}}, vtype_q[8:0]}; csr_ro = 1'b1; end
      CSR_VLENB:  begin csr_old = XLEN'(VLEN / 8); csr_ro = 1'b1; end
      default:    csr_known = 1'b0;
    endcase

    case (op_q)
      CSRRS:   csr_wdata = csr_old | rs1_data_q;
      CSRRC:   csr_wdata = csr_old & ~rs1_data_q;
      default: csr_wdata = rs1_data_q;
    endcase

    csr_we      = (op_q == CSRRW) || (rs1_addr_q != 5'd0);
    csr_illegal = !is_csr || !csr_known || (csr_ro && csr_we);
  end

  // NOTE: sequential state uses non-blocking assignments; later assignments in this
  // block override earlier ones, which encodes the CSR-write > set > clear priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      vl_q           <= '0;
      vlmax_q        <= '0;
      vtype_q        <= VTYPE_ILL;
      vstart_q       <= '0;
      vxrm_q         <= '0;
      vxsat_q        <= 1'b0;
      resp_valid_q   <= 1'b0;
      resp_data_q    <= '0;
      resp_illegal_q <= 1'b0;
    end else begin
      resp_valid_q <= 1'b0;
      if (vstart_clr) vstart_q <= '0;
      if (vstart_set) vstart_q <= vstart_wdata[VSTART_W-1:0];
      if (vxsat_set)  vxsat_q  <= 1'b1;

      case (state_q)
        ST_IDLE: if (req_valid) state_q <= ST_EXEC;
        ST_EXEC: begin
          state_q <= ST_RESP;
          if (is_vset) begin
            vl_q           <= vl_d;
            vlmax_q        <= cand_vlmax;
            vtype_q        <= cand_vill ? VTYPE_ILL
                              : '{vill: 1'b0, reserved: 1'b0, vma: cand.vma, vta: cand.vta,
                                  vsew: cand.vsew, vlmul: cand.vlmul};
            vstart_q       <= '0;
            resp_data_q    <= vl_d;
            resp_illegal_q <= 1'b0;
          end else if (csr_illegal) begin
            resp_data_q    <= '0;
            resp_illegal_q <= 1'b1;
          end else begin
            resp_data_q    <= csr_old;
            resp_illegal_q <= 1'b0;
            if (csr_we) begin
              case (csr_addr_q)
                CSR_VSTART: vstart_q <= csr_wdata[VSTART_W-1:0];
                CSR_VXSAT:  vxsat_q  <= csr_wdata[0];
                CSR_VXRM:   vxrm_q   <= csr_wdata[1:0];
                CSR_VCSR:   begin vxrm_q <= csr_wdata[2:1]; vxsat_q <= csr_wdata[0]; end
                default:    ;
              endcase
            end
          end
        end
        ST_RESP: begin
          state_q      <= ST_IDLE;
          resp_valid_q <= 1'b1;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  logic unused_bits;
  assign unused_bits = ^{vstart_wdata[XLEN-1:VSTART_W], csr_wdata[XLEN-1:VSTART_W], cand.vill};

  assign req_ready    = (state_q == ST_IDLE);
  assign resp_valid   = resp_valid_q;
  assign resp_data    = resp_data_q;
  assign resp_illegal = resp_illegal_q;
  assign vl           = vl_q;
  assign vlmax        = vlmax_q;
  assign vsew         = vtype_q.vsew;
  assign vlmul        = vtype_q.vlmul;
  assign vta          = vtype_q.vta;
  assign vma          = vtype_q.vma;
  assign vill         = vtype_q.vill;
  assign vstart       = XLEN'(vstart_q);
  assign vxrm         = vxrm_q;
  assign vxsat        = vxsat_q;

endmodule

// File: tb/tb_vec_csr_unit.sv
// Scoreboard bench for vec_csr_unit: stimulus queues expected responses, a negedge
// monitor pops and compares them (including accept-to-response latency).
module tb_vec_csr_unit;
  import vec_csr_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready;
  logic [2:0]  req_op;
  logic [4:0]  req_rd_addr, req_rs1_addr;
  logic [31:0] req_rs1_data, req_rs2_data;
  logic [10:0] req_zimm;
  logic [11:0] req_csr_addr;
  logic        resp_valid, resp_illegal;
  logic [31:0] resp_data;
  logic        vstart_set, vstart_clr, vxsat_set;
  logic [31:0] vstart_wdata;
  logic [31:0] vl, vlmax, vstart;
  logic [2:0]  vsew, vlmul;
  logic        vta, vma, vill, vxsat;
  logic [1:0]  vxrm;

  vec_csr_unit #(.XLEN(32), .VLEN(128), .ELEN(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_rd_addr(req_rd_addr), .req_rs1_addr(req_rs1_addr),
    .req_rs1_data(req_rs1_data), .req_rs2_data(req_rs2_data),
    .req_zimm(req_zimm), .req_csr_addr(req_csr_addr),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_illegal(resp_illegal),
    .vstart_set(vstart_set), .vstart_wdata(vstart_wdata), .vstart_clr(vstart_clr),
    .vxsat_set(vxsat_set),
    .vl(vl), .vlmax(vlmax), .vsew(vsew), .vlmul(vlmul), .vta(vta), .vma(vma),
    .vill(vill), .vstart(vstart), .vxrm(vxrm), .vxsat(vxsat)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic        illegal;
  } exp_t;

  exp_t exp_q[$];
  int   acc_q[$];
  int   neg_cnt = 0;
  int   n_checks = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: records accept times and scores every response pulse.
  always @(negedge clk) begin
    neg_cnt++;
    if (req_valid && req_ready && !rst) acc_q.push_back(neg_cnt);
    if (resp_valid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL unexpected_resp: got resp_valid=1 data=0x%0h expected no response", resp_data);
      end else begin
        exp_t e;
        int   a;
        e = exp_q.pop_front();
        a = (acc_q.size() != 0) ? acc_q.pop_front() : -100;
        check("resp_data", resp_data, e.data);
        check("resp_illegal", 32'(resp_illegal), 32'(e.illegal));
        check("resp_latency", 32'(neg_cnt - a), 32'd3);
      end
    end
  end

  task automatic issue(input op_e op, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [31:0] rs1d, input logic [31:0] rs2d,
                       input logic [10:0] zimm, input logic [11:0] csr,
                       input logic [31:0] exp_data, input logic exp_ill);
    int   g = 0;
    exp_t e;
    while (!req_ready && g < 20) begin @(posedge clk); #1; g++; end
    if (!req_ready) begin
      n_checks++; n_err++;
      $display("FAIL req_ready_timeout: got ready=0 expected ready=1");
    end
    req_op = op; req_rd_addr = rd; req_rs1_addr = rs1;
    req_rs1_data = rs1d; req_rs2_data = rs2d; req_zimm = zimm; req_csr_addr = csr;
    req_valid = 1'b1;
    e.data = exp_data; e.illegal = exp_ill;
    exp_q.push_back(e);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_resp();
    int g = 0;
    while (exp_q.size() != 0 && g < 10) begin @(posedge clk); #1; g++; end
    if (exp_q.size() != 0) begin
      n_checks++; n_err++;
      $display("FAIL resp_timeout: got %0d pending expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic run(input op_e op, input logic [4:0] rd, input logic [4:0] rs1,
                     input logic [31:0] rs1d, input logic [31:0] rs2d,
                     input logic [10:0] zimm, input logic [11:0] csr,
                     input logic [31:0] exp_data, input logic exp_ill);
    issue(op, rd, rs1, rs1d, rs2d, zimm, csr, exp_data, exp_ill);
    wait_resp();
  endtask

  // Fractional / illegal vtype vectors: zimm, AVL, expected vl, expected vill.
  typedef struct {
    logic [10:0] zimm;
    logic [31:0] avl;
    logic [31:0] vl;
    logic        vill;
  } vt_vec_t;

  vt_vec_t vt_tab[6];

  initial begin
    vt_tab[0] = '{zimm: 11'h006, avl: 32'd100,        vl: 32'd4,  vill: 1'b0}; // e8 mf4
    vt_tab[1] = '{zimm: 11'h017, avl: 32'd100,        vl: 32'd0,  vill: 1'b1}; // e32 mf2
    vt_tab[2] = '{zimm: 11'h005, avl: 32'd100,        vl: 32'd0,  vill: 1'b1}; // e8 mf8
    vt_tab[3] = '{zimm: 11'h004, avl: 32'd100,        vl: 32'd0,  vill: 1'b1}; // lmul rsvd
    vt_tab[4] = '{zimm: 11'h110, avl: 32'd100,        vl: 32'd0,  vill: 1'b1}; // reserved bit
    vt_tab[5] = '{zimm: 11'h013, avl: 32'hFFFF_FFF0,  vl: 32'd32, vill: 1'b0}; // e32 m8

    rst = 1'b1; req_valid = 1'b0; req_op = '0; req_rd_addr = '0; req_rs1_addr = '0;
    req_rs1_data = '0; req_rs2_data = '0; req_zimm = '0; req_csr_addr = '0;
    vstart_set = 1'b0; vstart_clr = 1'b0; vxsat_set = 1'b0; vstart_wdata = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_vl", vl, 32'd0);
    check("rst_vill", 32'(vill), 32'd1);
    check("rst_vlmax", vlmax, 32'd0);
    check("rst_vstart", vstart, 32'd0);
    check("rst_vxrm_vxsat", 32'({vxrm, vxsat}), 32'd0);

    run(VSETVLI, 5'd1, 5'd1, 32'd15, 32'd0, 11'h010, 12'h0, 32'd4, 1'b0);
    check("t1_vl", vl, 32'd4);
    check("t1_vlmax", vlmax, 32'd4);
    check("t1_vsew", 32'(vsew), 32'd2);
    check("t1_vill", 32'(vill), 32'd0);

    run(VSETIVLI, 5'd1, 5'd3, 32'd0, 32'd0, 11'h0C9, 12'h0, 32'd3, 1'b0);
    check("t2_vlmax", vlmax, 32'd16);
    check("t2_vl", vl, 32'd3);
    check("t2_vta_vma", 32'({vta, vma}), 32'd3);
    check("t2_lmul_sew", 32'({vlmul, vsew}), 32'({3'd1, 3'd1}));

    run(VSETVL, 5'd1, 5'd1, 32'd10, 32'h18, 11'h0, 12'h0, 32'd0, 1'b0);
    check("t3_vill", 32'(vill), 32'd1);
    check("t3_vl", vl, 32'd0);
    run(CSRRS, 5'd1, 5'd0, 32'd0, 32'd0, 11'h0, CSR_VTYPE, 32'h8000_0000, 1'b0);

    run(VSETVLI, 5'd5, 5'd0, 32'd0, 32'd0, 11'h003, 12'h0, 32'd128, 1'b0);
    check("t4_vl_max", vl, 32'd128);
    run(VSETVLI, 5'd0, 5'd0, 32'd0, 32'd0, 11'h010, 12'h0, 32'd4, 1'b0);
    check("t4_vl_keep", vl, 32'd4);
    run(CSRRS, 5'd1, 5'd0, 32'd0, 32'd0, 11'h0, CSR_VL, 32'd4, 1'b0);
    run(CSRRS, 5'd1, 5'd0, 32'd0, 32'd0, 11'h0, CSR_VLENB, 32'd16, 1'b0);

    for (int i = 0; i < 6; i++) begin
      run(VSETVLI, 5'd1, 5'd1, vt_tab[i].avl, 32'd0, vt_tab[i].zimm, 12'h0, vt_tab[i].vl, 1'b0);
      check($sformatf("vt%0d_vill", i), 32'(vill), 32'(vt_tab[i].vill));
      check($sformatf("vt%0d_vl", i), vl, vt_tab[i].vl);
    end
    run(VSETVL, 5'd1, 5'd1, 32'd10, 32'h110, 11'h0, 12'h0, 32'd0, 1'b0);
    check("vsetvl_rsvd_vill", 32'(vill), 32'd1);

    // vstart masked to 7 bits, then cleared by a vset.
    run(CSRRW, 5'd1, 5'd1, 32'h1FF, 32'd0, 11'h0, CSR_VSTART, 32'd0, 1'b0);
    check("vstart_mask", vstart, 32'h7F);
    run(VSETIVLI, 5'd1, 5'd1, 32'd0, 32'd0, 11'h010, 12'h0, 32'd1, 1'b0);
    check("vstart_vset_clr", vstart, 32'd0);

    run(CSRRW, 5'd1, 5'd1, 32'd7, 32'd0, 11'h0, CSR_VCSR, 32'd0, 1'b0);
    check("t5_vxrm", 32'(vxrm), 32'd3);
    check("t5_vxsat", 32'(vxsat), 32'd1);
    run(CSRRC, 5'd1, 5'd1, 32'd1, 32'd0, 11'h0, CSR_VXSAT, 32'd1, 1'b0);
    check("csrrc_vxsat", 32'(vxsat), 32'd0);
    run(CSRRS, 5'd1, 5'd0, 32'd0, 32'd0, 11'h0, CSR_VXRM, 32'd3, 1'b0);
    run(CSRRW, 5'd1, 5'd1, 32'd9, 32'd0, 11'h0, CSR_VL, 32'd0, 1'b1);
    check("t5_vl_unchanged", vl, 32'd1);
    run(CSRRW, 5'd1, 5'd1, 32'd9, 32'd0, 11'h0, 12'h123, 32'd0, 1'b1);
    run(CSRRS, 5'd1, 5'd0, 32'd0, 32'd0, 11'h0, CSR_VTYPE, 32'h10, 1'b0);

    vxsat_set = 1'b1; @(posedge clk); #1 vxsat_set = 1'b0;
    check("vxsat_set", 32'(vxsat), 32'd1);
    vstart_set = 1'b1; vstart_clr = 1'b1; vstart_wdata = 32'd5;
    @(posedge clk); #1 vstart_set = 1'b0; vstart_clr = 1'b0;
    check("vstart_set_over_clr", vstart, 32'd5);
    vstart_clr = 1'b1; @(posedge clk); #1 vstart_clr = 1'b0;
    check("vstart_clr", vstart, 32'd0);

    // CSR write to vstart wins over a coincident trap on the EXEC edge.
    issue(CSRRW, 5'd1, 5'd1, 32'd9, 32'd0, 11'h0, CSR_VSTART, 32'd0, 1'b0);
    vstart_set = 1'b1; vstart_wdata = 32'd20;
    @(posedge clk); #1 vstart_set = 1'b0;
    wait_resp();
    check("vstart_csr_over_set", vstart, 32'd9);

    // Reset while a request sits in EXEC: no response, reset state restored.
    req_op = VSETIVLI; req_rd_addr = 5'd1; req_rs1_addr = 5'd7; req_zimm = 11'h010;
    req_valid = 1'b1;
    @(posedge clk); #1 req_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    repeat (6) @(posedge clk);
    #1 acc_q.delete();
    check("rst2_vl", vl, 32'd0);
    check("rst2_vill", 32'(vill), 32'd1);
    check("rst2_vxrm", 32'(vxrm), 32'd0);
    check("rst2_vxsat", 32'(vxsat), 32'd0);
    check("rst2_vstart", vstart, 32'd0);
    check("rst2_ready", 32'(req_ready), 32'd1);

    run(VSETIVLI, 5'd1, 5'd2, 32'd0, 32'd0, 11'h010, 12'h0, 32'd2, 1'b0);
    check("post_rst_vl", vl, 32'd2);

    repeat (4) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/vec_csr_unit.md
Name: vec_csr_unit

Overview:
- Parametrised vector configuration/CSR unit; successor to the fixed VLMAX=16, 32-bit vector CSR decoder.
- Executes vsetvli, vsetivli and vsetvl, plus Zicsr access to vstart, vxsat, vxrm, vcsr, vl, vtype and vlenb.
- Supports fractional LMUL, the vill rule and the AVL=x0 rules, using a valid/ready request and a fixed-latency response.
- Sits between the scalar decode/issue stage and the vector datapath.

Parameters:
- XLEN, 32, scalar register and CSR data width.
- VLEN, 128, vector register length in bits; power of 2, 64..1024.
- ELEN, 32, maximum legal element width in bits (32 or 64).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request; high only in IDLE.
- req_op  in  3  vec_csr_pkg::op_e: VSETVLI, VSETIVLI, VSETVL, CSRRW, CSRRS, CSRRC.
- req_rd_addr  in  5  destination register index; used only for the x0 rules.
- req_rs1_addr  in  5  rs1 index; doubles as uimm for VSETIVLI.
- req_rs1_data  in  XLEN  AVL, or the CSR write operand.
- req_rs2_data  in  XLEN  vtype operand for VSETVL.
- req_zimm  in  11  vtype immediate for VSETVLI/VSETIVLI. Bits [7:0] are used; bits [10:8] are reserved and must be zero.
- req_csr_addr  in  12  CSR address for CSR ops.
- resp_valid  out  1  one-cycle response pulse.
- resp_data  out  XLEN  new vl (vset*) or old CSR value (CSR ops).
- resp_illegal  out  1  illegal CSR access; valid only with resp_valid.
- vstart_set  in  1  datapath trap: load vstart_wdata into vstart.
- vstart_wdata  in  XLEN  trap element index.
- vstart_clr  in  1  vector instruction completed: clear vstart.
- vxsat_set  in  1  saturation occurred.
- vl  out  XLEN  current vector length.
- vlmax  out  XLEN  VLMAX for the current vtype; 0 when vill=1.
- vsew  out  3  SEW encoding.
- vlmul  out  3  LMUL encoding.
- vta  out  1  tail agnostic.
- vma  out  1  mask agnostic.
- vill  out  1  illegal vtype.
- vstart  out  XLEN  start element.
- vxrm  out  2  fixed-point rounding mode.
- vxsat  out  1  saturation flag.

Behaviour:
- Reset values, applied synchronously when rst=1, from any state:
  - vl=0, vill=1, vsew=0, vlmul=0, vta=0, vma=0.
  - vstart=0, vxrm=0, vxsat=0.
  - resp_valid=0, resp_data=0, resp_illegal=0.
  - State goes to IDLE. An in-flight request is dropped with no response.
- FSM: IDLE -> EXEC -> RESP -> IDLE.
  - IDLE: a request is accepted when req_valid && req_ready.
  - EXEC: computes the result. All architectural CSR state updates on the clock edge that leaves EXEC.
  - RESP: resp_valid=1 for exactly one cycle; resp_data and resp_illegal are driven in that cycle.
  - Latency: accepted at edge N -> resp_valid high in the cycle after edge N+2. Throughput is 1 request per 3 cycles. There is no response backpressure.
- vtype fields: vlmul=[2:0], vsew=[5:3], vta=[6], vma=[7].
  - For VSETVL the source is req_rs2_data. Any nonzero rs2 bit [XLEN-1:8] makes the vtype illegal.
- vill=1 when any of these hold:
  - vsew >= 3'b100.
  - SEW > ELEN.
  - vlmul = 3'b100.
  - Fractional LMUL with SEW > ELEN*LMUL.
  - A reserved bit is nonzero.
- On vill: vl=0, all other vtype fields=0, and a CSR read of vtype returns 1<<(XLEN-1).
- VLMAX = (VLEN >> (vsew+3)), then shifted left by vlmul for vlmul 0..3, or shifted right by (8-vlmul) for vlmul 5..7.
- AVL selection:
  - VSETIVLI: AVL = zero-extended uimm.
  - rs1!=x0: AVL = rs1_data.
  - rs1=x0, rd!=x0: AVL = all ones, so vl=VLMAX.
  - rs1=x0, rd=x0: vl = min(old vl, VLMAX).
- vl = min(AVL, VLMAX). Comparison is unsigned over the full XLEN width.
- resp_data = the new vl. Every vset* also clears vstart.
- CSR addresses: vstart 0x008, vxsat 0x009, vxrm 0x00A, vcsr 0x00F (value = {vxrm, vxsat}), vl 0xC20, vtype 0xC21, vlenb 0xC22 (= VLEN/8).
- CSR write rules:
  - CSRRS/CSRRC with rs1=x0 perform no write.
  - A write to a read-only CSR (0xC2x) or any unknown address sets resp_illegal=1 with no state change and resp_data=0.
  - Writes are masked to field width; vstart is masked to log2(VLEN) bits.
- Update priority when events coincide:
  - vstart: CSR write > vstart_set > vstart_clr.
  - vxsat: CSR write > vxsat_set.
- vstart_set, vstart_clr and vxsat_set act in any FSM state.

Decomposition:
- vec_csr_pkg holds: op_e; the CSR address localparams; the vtype_t packed struct {vill, reserved, vma, vta, vsew, vlmul}; and the SEW/LMUL encodings.
- One combinational sub-module, vec_vlmax_calc, maps (vsew, vlmul) to (vlmax, vill).

Test Plan:
- VSETVLI, rs1=x1, rs1_data=15, zimm=0x010 -> resp_valid 2 cycles after accept, resp_data=4, vl=4, vlmax=4, vsew=2, vill=0.
- VSETIVLI, uimm=3, zimm=0x0C9 -> vlmax=16, vl=3, vta=1, vma=1.
- VSETVL, rs2_data=0x18 (e64 with ELEN=32) -> vill=1, vl=0, resp_data=0; a following CSRRS on 0xC21 with rs1=x0 returns 0x80000000.
- VSETVLI, rs1=x0, rd=x5, zimm=0x003 -> vl=128. Then rs1=x0, rd=x0 with zimm=0x010 -> vl=4.
- CSRRW 0x00F with data 7 -> vxrm=3, vxsat=1. Then CSRRW 0xC20 -> resp_illegal=1 and vl unchanged.
- rst asserted during EXEC -> resp_valid never rises and all outputs return to reset values. Separately, vstart_set (wdata 5) together with vstart_clr in the same cycle -> vstart=5.
